// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : Byte-wide UART transmitter. Each byte is sent as a start bit,
//               8 data bits LSB first, optional parity, and 1 or 2 stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter int CLK_DIV   = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk50m,
    input  logic       reset_n,
    input  logic [7:0] txdata,
    input  logic       txvalid,
    output logic       txready,
    output logic       txd,
    output logic       busy,
    output logic       txdone
);

    // Out-of-range PARITY / STOP_BITS values fall back to no parity / one stop bit.
    localparam logic [15:0] c_div_m1   = 16'(CLK_DIV - 1);
    localparam logic        c_par_en   = (PARITY == 1) || (PARITY == 2);
    localparam logic        c_par_odd  = (PARITY == 2);
    localparam logic        c_two_stop = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_cnt,   w_cnt;
    logic [2:0]  r_idx,   w_idx;
    logic [7:0]  r_shift, w_shift;
    logic        r_par,   w_par;
    logic        r_stop,  w_stop;
    logic        r_txd,   w_txd;
    logic        r_ready;
    logic        r_busy;
    logic        r_done,  w_done;
    logic        w_tick;

    always_ff @(posedge clk50m) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_stop  <= 1'b0;
            r_txd   <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_stop  <= w_stop;
            r_txd   <= w_txd;
            // Outputs are registered from the next state so they line up with it.
            r_ready <= (w_state == S_IDLE);
            r_busy  <= (w_state != S_IDLE);
            r_done  <= w_done;
        end
    end

    assign w_tick = (r_cnt == c_div_m1);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_shift = r_shift;
        w_par   = r_par;
        w_stop  = r_stop;
        w_done  = 1'b0;
        w_txd   = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                // r_ready is only high in IDLE, and stays low for the first cycle out of reset.
                if (txvalid && r_ready) begin
                    w_shift = txdata;
                    w_par   = c_par_odd ? ~^txdata : ^txdata;
                    w_cnt   = 16'd0;
                    w_idx   = 3'd0;
                    w_stop  = 1'b0;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_cnt   = 16'd0;
                    w_idx   = 3'd0;
                    w_state = S_DATA;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt   = 16'd0;
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_stop  = 1'b0;
                        w_state = c_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_cnt   = 16'd0;
                    w_stop  = 1'b0;
                    w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_cnt = 16'd0;
                    if (c_two_stop && !r_stop) begin
                        w_stop = 1'b1;
                    end else begin
                        w_stop  = 1'b0;
                        w_done  = 1'b1;
                        w_state = S_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_cnt   = 16'd0;
                w_state = S_IDLE;
            end
        endcase

        case (w_state)
            S_START:  w_txd = 1'b0;
            S_DATA:   w_txd = w_shift[0];
            S_PARITY: w_txd = w_par;
            default:  w_txd = 1'b1;
        endcase
    end

    assign txready = r_ready;
    assign txd     = r_txd;
    assign busy    = r_busy;
    assign txdone  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx (8N1, 8E2, 8O2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] txdata  = 8'h00;
    logic       txvalid = 1'b0;

    logic a_ready, a_txd, a_busy, a_done;
    logic b_ready, b_txd, b_busy, b_done;
    logic c_ready, c_txd, c_busy, c_done;

    int total = 0;
    int bad   = 0;

    uart_tx #(.CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk50m(clk), .reset_n(reset_n), .txdata(txdata), .txvalid(txvalid),
        .txready(a_ready), .txd(a_txd), .busy(a_busy), .txdone(a_done));
    uart_tx #(.CLK_DIV(4), .PARITY(1), .STOP_BITS(2)) u_b (
        .clk50m(clk), .reset_n(reset_n), .txdata(txdata), .txvalid(txvalid),
        .txready(b_ready), .txd(b_txd), .busy(b_busy), .txdone(b_done));
    uart_tx #(.CLK_DIV(4), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk50m(clk), .reset_n(reset_n), .txdata(txdata), .txvalid(txvalid),
        .txready(c_ready), .txd(c_txd), .busy(c_busy), .txdone(c_done));

    always #5 clk = ~clk;

    // Expected line level during frame bit k (0 = start bit).
    function automatic logic exp_bit(input logic [7:0] d, input int k, input int par);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && par == 1) return ^d;
        if (k == 9 && par == 2) return ~^d;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        txvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        txvalid = 1'b1;
        txdata  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({a_txd, a_ready, a_busy, a_done} !== 4'b1000) begin
                bad++;
                $display("FAIL reset_hold i=%0d got=%b exp=1000", i, {a_txd, a_ready, a_busy, a_done});
            end
        end
        txvalid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({a_ready, a_busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release got=%b exp=10", {a_ready, a_busy});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({a_txd, a_busy, a_done} !== 3'b100) begin
                bad++;
                $display("FAIL reset_idle i=%0d got=%b exp=100", i, {a_txd, a_busy, a_done});
            end
        end
    endtask

    task automatic test_basic_8n1();
        do_reset();
        txdata  = 8'h55;
        txvalid = 1'b1;
        @(negedge clk);
        txvalid = 1'b0;
        for (int j = 0; j < 42; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 40) begin
                total++;
                if (a_txd !== exp_bit(8'h55, j / 4, 0)) begin
                    bad++;
                    $display("FAIL basic_txd j=%0d got=%b exp=%b", j, a_txd, exp_bit(8'h55, j / 4, 0));
                end
                total++;
                if ({a_busy, a_ready, a_done} !== 3'b100) begin
                    bad++;
                    $display("FAIL basic_flags j=%0d got=%b exp=100", j, {a_busy, a_ready, a_done});
                end
            end else if (j == 40) begin
                total++;
                if ({a_txd, a_busy, a_ready, a_done} !== 4'b1011) begin
                    bad++;
                    $display("FAIL basic_done got=%b exp=1011", {a_txd, a_busy, a_ready, a_done});
                end
            end else begin
                total++;
                if (a_done !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_done_width got=%b exp=0", a_done);
                end
            end
        end
    endtask

    task automatic test_parity_2stop();
        do_reset();
        txdata  = 8'h07;
        txvalid = 1'b1;
        @(negedge clk);
        txvalid = 1'b0;
        for (int j = 0; j < 49; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 48) begin
                total++;
                if (b_txd !== exp_bit(8'h07, j / 4, 1)) begin
                    bad++;
                    $display("FAIL even_txd j=%0d got=%b exp=%b", j, b_txd, exp_bit(8'h07, j / 4, 1));
                end
                total++;
                if (c_txd !== exp_bit(8'h07, j / 4, 2)) begin
                    bad++;
                    $display("FAIL odd_txd j=%0d got=%b exp=%b", j, c_txd, exp_bit(8'h07, j / 4, 2));
                end
                total++;
                if ({b_busy, b_done, c_busy, c_done} !== 4'b1010) begin
                    bad++;
                    $display("FAIL par_flags j=%0d got=%b exp=1010", j, {b_busy, b_done, c_busy, c_done});
                end
            end else begin
                total++;
                if ({b_txd, b_busy, b_done, c_txd, c_busy, c_done} !== 6'b101101) begin
                    bad++;
                    $display("FAIL par_done got=%b exp=101101", {b_txd, b_busy, b_done, c_txd, c_busy, c_done});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        bytes[0] = 8'hA3;
        bytes[1] = 8'h3C;
        do_reset();
        txdata  = bytes[0];
        txvalid = 1'b1;
        @(negedge clk);
        txdata  = bytes[1];
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                @(negedge clk);
                txvalid = 1'b0;
            end
            for (int j = 0; j < 41; j++) begin
                if (j > 0) @(negedge clk);
                if (j < 40) begin
                    total++;
                    if (a_txd !== exp_bit(bytes[f], j / 4, 0)) begin
                        bad++;
                        $display("FAIL b2b_txd f=%0d j=%0d got=%b exp=%b", f, j, a_txd, exp_bit(bytes[f], j / 4, 0));
                    end
                    total++;
                    if ({a_busy, a_ready, a_done} !== 3'b100) begin
                        bad++;
                        $display("FAIL b2b_flags f=%0d j=%0d got=%b exp=100", f, j, {a_busy, a_ready, a_done});
                    end
                end else begin
                    total++;
                    if ({a_txd, a_busy, a_ready, a_done} !== 4'b1011) begin
                        bad++;
                        $display("FAIL b2b_done f=%0d got=%b exp=1011", f, {a_txd, a_busy, a_ready, a_done});
                    end
                end
            end
        end
    endtask

    task automatic test_stability();
        do_reset();
        txdata  = 8'hF0;
        txvalid = 1'b1;
        @(negedge clk);
        txdata  = 8'h0F;
        txvalid = 1'b0;
        for (int j = 0; j < 45; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 10) txvalid = 1'b1;
            if (j == 11) txvalid = 1'b0;
            if (j < 40) begin
                total++;
                if (a_txd !== exp_bit(8'hF0, j / 4, 0)) begin
                    bad++;
                    $display("FAIL stable_txd j=%0d got=%b exp=%b", j, a_txd, exp_bit(8'hF0, j / 4, 0));
                end
            end else if (j == 40) begin
                total++;
                if (a_done !== 1'b1) begin
                    bad++;
                    $display("FAIL stable_done got=%b exp=1", a_done);
                end
            end else begin
                total++;
                if ({a_txd, a_busy, a_done} !== 3'b100) begin
                    bad++;
                    $display("FAIL stable_no_extra j=%0d got=%b exp=100", j, {a_txd, a_busy, a_done});
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        txdata  = 8'hC3;
        txvalid = 1'b1;
        @(negedge clk);
        txvalid = 1'b0;
        for (int j = 0; j < 18; j++) begin
            if (j > 0) @(negedge clk);
            total++;
            if (a_txd !== exp_bit(8'hC3, j / 4, 0)) begin
                bad++;
                $display("FAIL mid_pre_txd j=%0d got=%b exp=%b", j, a_txd, exp_bit(8'hC3, j / 4, 0));
            end
        end
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({a_txd, a_ready, a_busy, a_done} !== 4'b1000) begin
                bad++;
                $display("FAIL mid_reset i=%0d got=%b exp=1000", i, {a_txd, a_ready, a_busy, a_done});
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({a_txd, a_ready, a_done} !== 3'b110) begin
            bad++;
            $display("FAIL mid_release got=%b exp=110", {a_txd, a_ready, a_done});
        end
        txdata  = 8'h96;
        txvalid = 1'b1;
        @(negedge clk);
        txvalid = 1'b0;
        for (int j = 0; j < 41; j++) begin
            if (j > 0) @(negedge clk);
            if (j < 40) begin
                total++;
                if ({a_txd, a_done} !== {exp_bit(8'h96, j / 4, 0), 1'b0}) begin
                    bad++;
                    $display("FAIL mid_resend j=%0d got=%b exp=%b", j, {a_txd, a_done}, {exp_bit(8'h96, j / 4, 0), 1'b0});
                end
            end else begin
                total++;
                if ({a_txd, a_busy, a_done} !== 3'b101) begin
                    bad++;
                    $display("FAIL mid_resend_done got=%b exp=101", {a_txd, a_busy, a_done});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity_2stop();
        test_back_to_back();
        test_stability();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
